// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte-wide asynchronous serial transmitter with a small input FIFO.
// Bytes enter through a valid/ready handshake, queue in a circular buffer and
// are shifted out LSB first on TxD. Bit timing comes from a fractional
// phase-accumulator baud generator.
//
// Build option:
//   UART_TX_PARITY_EN  adds parameter ParityOdd and a parity bit after D7
//                      (8E1/8O1 frames). When the macro is undefined, the
//                      frame is 8N1 (or 8N2).
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous, active-low reset
//   TxD_start  in   byte valid
//   TxD_data   in   byte to send, taken when TxD_start && TxD_ready
//   TxD_ready  out  FIFO not full
//   TxD        out  serial line, idles high, registered
//   TxD_busy   out  frame on the line or bytes still queued
module uart_tx_fifo #(
    parameter int ClkFrequency = 50000000,
    parameter int Baud         = 115200,
    parameter int FifoDepth    = 4,
    parameter int StopBits     = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit ParityOdd    = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       TxD_start,
    input  logic [7:0] TxD_data,
    output logic       TxD_ready,
    output logic       TxD,
    output logic       TxD_busy
);

    localparam int Ratio = ClkFrequency / Baud;
    localparam int AccW  = $clog2(Ratio + 1) + 8;
    // Rounded increment: Baud * 2^AccW / ClkFrequency
    localparam logic [63:0] IncWide =
        ((64'(Baud) << AccW) + 64'(ClkFrequency / 2)) / 64'(ClkFrequency);
    localparam logic [AccW:0] Inc = IncWide[AccW:0];

    localparam int AW   = $clog2(FifoDepth);
    localparam int PtrW = AW + 1;

    generate
        if (ClkFrequency < 2 * Baud) begin : gBadBaud
            $error("uart_tx_fifo: ClkFrequency must be at least 2*Baud");
        end
        if ((FifoDepth < 2) || (FifoDepth > 16) || ((1 << AW) != FifoDepth)) begin : gBadDepth
            $error("uart_tx_fifo: FifoDepth must be a power of 2 in 2..16");
        end
        if ((StopBits != 1) && (StopBits != 2)) begin : gBadStop
            $error("uart_tx_fifo: StopBits must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PAR,
`endif
        S_STOP1,
        S_STOP2
    } state_t;

    state_t          r_state;
    logic [2:0]      r_bitIdx;
    logic [7:0]      r_sh;
    logic            r_txd;
    logic            r_busy;
    logic [AccW:0]   r_acc;
    logic [7:0]      r_mem [FifoDepth];
    logic [PtrW-1:0] r_wrPtr;
    logic [PtrW-1:0] r_rdPtr;

    logic [PtrW-1:0] w_count;
    logic            w_empty;
    logic            w_ready;
    logic            w_push;
    logic            w_pop;
    logic            w_tick;
    logic            w_lastStop;
    logic            w_lineBit;

    // Pointers are one bit wider than the index so full and empty differ.
    assign w_count = r_wrPtr - r_rdPtr;
    assign w_empty = (w_count == '0);
    assign w_ready = (w_count != PtrW'(FifoDepth));
    assign w_push  = TxD_start && w_ready;

    assign w_tick     = r_acc[AccW];
    assign w_lastStop = (r_state == S_STOP2) ||
                        ((r_state == S_STOP1) && (StopBits != 2));
    // A pop happens when leaving IDLE or at the final stop tick, and only
    // with data queued, so a push and pop on an empty FIFO cannot coincide.
    assign w_pop = !w_empty && ((r_state == S_IDLE) || (w_lastStop && w_tick));

    assign TxD_ready = w_ready;
    assign TxD       = r_txd;
    assign TxD_busy  = r_busy;

    // Baud generator. Leaving IDLE preloads one increment so the start bit
    // lasts exactly as long as every other bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (r_state == S_IDLE) begin
            r_acc <= w_empty ? '0 : Inc;
        end else begin
            r_acc <= {1'b0, r_acc[AccW-1:0]} + Inc;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr[AW-1:0]] <= TxD_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PtrW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PtrW'(1);
            end
        end
    end

    // Line level for the current state; registered one cycle later into TxD.
    always_comb begin
        w_lineBit = 1'b1;
        case (r_state)
            S_START: w_lineBit = 1'b0;
            S_DATA:  w_lineBit = r_sh[r_bitIdx];
`ifdef UART_TX_PARITY_EN
            S_PAR:   w_lineBit = (^r_sh) ^ ParityOdd;
`endif
            default: w_lineBit = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_bitIdx <= '0;
            r_sh     <= '0;
            r_txd    <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            r_txd  <= w_lineBit;
            r_busy <= (r_state != S_IDLE) || !w_empty;
            if (w_pop) begin
                r_sh <= r_mem[r_rdPtr[AW-1:0]];
            end
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_state  <= S_DATA;
                        r_bitIdx <= '0;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_bitIdx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= S_PAR;
`else
                            r_state <= S_STOP1;
`endif
                        end else begin
                            r_bitIdx <= r_bitIdx + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PAR: begin
                    if (w_tick) begin
                        r_state <= S_STOP1;
                    end
                end
`endif
                S_STOP1: begin
                    if (w_tick) begin
                        if (StopBits == 2) begin
                            r_state <= S_STOP2;
                        end else begin
                            r_state <= w_empty ? S_IDLE : S_START;
                        end
                    end
                end
                S_STOP2: begin
                    if (w_tick) begin
                        r_state <= w_empty ? S_IDLE : S_START;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
